// File: rtl/alu_seq_if.sv
// Handshaked operand/result channel of alu_seq. The master drives operations
// and consumes results; the slave (the ALU) returns results with flags.
interface alu_seq_if #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [SEL_W-1:0] ALU_Sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALU_Out;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output in_valid, A, B, ALU_Sel, out_ready,
    input  in_ready, out_valid, ALU_Out, flag_z, flag_n, flag_c, flag_v
  );

  modport slave (
    input  in_valid, A, B, ALU_Sel, out_ready,
    output in_ready, out_valid, ALU_Out, flag_z, flag_n, flag_c, flag_v
  );
endinterface

// File: rtl/alu_seq.sv
// Registered, handshaked ALU: one op per transfer, result held until consumed.
// Define ALU_SEQ_MUL_EN for the iterative shift-add multiply on opcode 111.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 3
) (
    input logic   clk,
    input logic   rst,
    alu_seq_if.slave bus
);
  localparam int MSB = WIDTH - 1;
  localparam logic [SEL_W-1:0] OP_PASS = SEL_W'(0);
  localparam logic [SEL_W-1:0] OP_ADD  = SEL_W'(1);
  localparam logic [SEL_W-1:0] OP_SUB  = SEL_W'(2);
  localparam logic [SEL_W-1:0] OP_CLR  = SEL_W'(3);
  localparam logic [SEL_W-1:0] OP_AND  = SEL_W'(4);
  localparam logic [SEL_W-1:0] OP_OR   = SEL_W'(5);
  localparam logic [SEL_W-1:0] OP_XOR  = SEL_W'(6);
  localparam logic [SEL_W-1:0] OP_MUL  = SEL_W'(7);

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  localparam int CNT_W = $clog2(WIDTH + 1);
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [2*WIDTH-1:0] a_shift_reg, a_shift_next;
  logic [WIDTH-1:0]   b_shift_reg, b_shift_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic [3:0]       flags_reg, flags_next;  // {c, v, z, n}

  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [WIDTH-1:0] and_bits, or_bits, xor_bits;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  assign sum_ext  = {1'b0, bus.A} + {1'b0, bus.B};
  assign diff_ext = {1'b0, bus.A} - {1'b0, bus.B};

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_logic
      assign and_bits[gi] = bus.A[gi] & bus.B[gi];
      assign or_bits[gi]  = bus.A[gi] | bus.B[gi];
      assign xor_bits[gi] = bus.A[gi] ^ bus.B[gi];
    end
  endgenerate

  // Single-cycle result; opcode 111 falls through to pass A when multiply is absent.
  always_comb begin
    alu_res = bus.A;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.ALU_Sel)
      OP_PASS: alu_res = bus.A;
      OP_ADD: begin
        alu_res = sum_ext[MSB:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (bus.A[MSB] == bus.B[MSB]) && (sum_ext[MSB] != bus.A[MSB]);
      end
      OP_SUB: begin
        alu_res = diff_ext[MSB:0];
        alu_c   = diff_ext[WIDTH];
        alu_v   = (bus.A[MSB] != bus.B[MSB]) && (diff_ext[MSB] != bus.A[MSB]);
      end
      OP_CLR:  alu_res = '0;
      OP_AND:  alu_res = and_bits;
      OP_OR:   alu_res = or_bits;
      OP_XOR:  alu_res = xor_bits;
      OP_MUL:  alu_res = bus.A;
      default: alu_res = bus.A;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    flags_next = flags_reg;
`ifdef ALU_SEQ_MUL_EN
    acc_next     = acc_reg;
    a_shift_next = a_shift_reg;
    b_shift_next = b_shift_reg;
    cnt_next     = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          out_next   = alu_res;
          flags_next = {alu_c, alu_v, (alu_res == '0), alu_res[MSB]};
          state_next = DONE;
`ifdef ALU_SEQ_MUL_EN
          if (bus.ALU_Sel == OP_MUL) begin
            out_next     = out_reg;
            flags_next   = flags_reg;
            acc_next     = '0;
            a_shift_next = {{WIDTH{1'b0}}, bus.A};
            b_shift_next = bus.B;
            cnt_next     = '0;
            state_next   = BUSY;
          end
`endif
        end
      end
`ifdef ALU_SEQ_MUL_EN
      BUSY: begin
        // All WIDTH iterations always run, then one extra cycle to publish.
        if (cnt_reg == CNT_W'(WIDTH)) begin
          out_next   = acc_reg[MSB:0];
          flags_next = {(acc_reg[2*WIDTH-1:WIDTH] != '0), 1'b0,
                        (acc_reg[MSB:0] == '0), acc_reg[MSB]};
          state_next = DONE;
        end else begin
          acc_next     = acc_reg + (b_shift_reg[0] ? a_shift_reg : '0);
          a_shift_next = a_shift_reg << 1;
          b_shift_next = b_shift_reg >> 1;
          cnt_next     = cnt_reg + 1'b1;
        end
      end
`endif
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      out_reg   <= '0;
      flags_reg <= '0;
`ifdef ALU_SEQ_MUL_EN
      acc_reg     <= '0;
      a_shift_reg <= '0;
      b_shift_reg <= '0;
      cnt_reg     <= '0;
`endif
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      flags_reg <= flags_next;
`ifdef ALU_SEQ_MUL_EN
      acc_reg     <= acc_next;
      a_shift_reg <= a_shift_next;
      b_shift_reg <= b_shift_next;
      cnt_reg     <= cnt_next;
`endif
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.ALU_Out   = out_reg;
  assign bus.flag_c    = flags_reg[3];
  assign bus.flag_v    = flags_reg[2];
  assign bus.flag_z    = flags_reg[1];
  assign bus.flag_n    = flags_reg[0];
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: an arithmetic reference model with a
// per-cycle scoreboard, directed literal cases, then randomized traffic.
module tb_alu_seq;
  localparam int W = 16;
  localparam longint MOD  = longint'(1) << W;
  localparam longint HALF = longint'(1) << (W - 1);
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W), .SEL_W(3)) bus ();
  alu_seq #(.WIDTH(W), .SEL_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit started = 1'b0;
  bit rst_seen = 1'b1;

  typedef struct {
    logic [W+3:0] exp;  // {c, v, z, n, result}
    int           due;  // edge number after which the result is visible
  } item_t;
  item_t q[$];
  logic [W+3:0] last = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic longint to_signed(input longint u);
    return (u >= HALF) ? u - MOD : u;
  endfunction

  // Expected {c, v, z, n, result} from plain integer arithmetic.
  function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] sel);
    longint ia, ib, r, st;
    logic c, v;
    logic [W-1:0] res;
    ia = longint'(a);
    ib = longint'(b);
    c = 1'b0;
    v = 1'b0;
    r = 0;
    case (sel)
      3'd0: r = ia;
      3'd1: begin
        r = ia + ib;
        c = (r >= MOD);
        st = to_signed(ia) + to_signed(ib);
        v = (st >= HALF) || (st < -HALF);
      end
      3'd2: begin
        r = ia - ib;
        c = (ia < ib);
        st = to_signed(ia) - to_signed(ib);
        v = (st >= HALF) || (st < -HALF);
      end
      3'd3: r = 0;
      3'd4: r = ia & ib;
      3'd5: r = ia | ib;
      3'd6: r = ia ^ ib;
      default: begin
        if (MUL_EN) begin
          r = ia * ib;
          c = (r / MOD) != 0;
        end else begin
          r = ia;
        end
      end
    endcase
    if (r < 0) r = r + MOD;
    r = r % MOD;
    res = r[W-1:0];
    return {c, v, (r == 0), (r >= HALF), res};
  endfunction

  // Scoreboard bookkeeping on the active edge (inputs are stable here).
  always @(posedge clk) begin
    item_t it;
    cyc++;
    started = 1'b1;
    if (rst) begin
      q.delete();
      last = '0;
      rst_seen = 1'b1;
    end else begin
      rst_seen = 1'b0;
      if (q.size() > 0 && bus.out_valid && bus.out_ready) begin
        last = q[0].exp;
        void'(q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        it.exp = model(bus.A, bus.B, bus.ALU_Sel);
        it.due = (MUL_EN && bus.ALU_Sel == 3'd7) ? cyc + W + 1 : cyc;
        q.push_back(it);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [W+3:0] e;
    logic ev, er;
    if (started) begin
      if (rst_seen) begin
        e = '0;
        ev = 1'b0;
        er = 1'b1;
      end else begin
        er = (q.size() == 0);
        ev = (q.size() > 0) && (cyc >= q[0].due);
        e = ev ? q[0].exp : last;
      end
      chk("in_ready", bus.in_ready, er);
      chk("out_valid", bus.out_valid, ev);
      chk("alu_out", bus.ALU_Out, e[W-1:0]);
      chk("flags_cvzn", {bus.flag_c, bus.flag_v, bus.flag_z, bus.flag_n}, e[W+3:W]);
    end
  end

  // lat = edges from the accepting edge to the edge that publishes the result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sel,
                        input int stall, output logic [W-1:0] res, output logic [3:0] fl,
                        output int lat);
    int n;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.ALU_Sel = sel;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A = W'($urandom);
    bus.B = W'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("result_timeout", bus.out_valid, 1'b1);
    res = bus.ALU_Out;
    fl = {bus.flag_c, bus.flag_v, bus.flag_z, bus.flag_n};
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'b1;
      bus.ALU_Sel = 3'($urandom);
      chk("stall_in_ready", bus.in_ready, 1'b0);
      chk("stall_hold", bus.ALU_Out, res);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("release_idle", {bus.out_valid, bus.in_ready}, 2'b01);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom % 5)
      0: return '1;
      1: return W'(HALF);
      2: return W'($urandom % 3);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic [W-1:0] res;
    logic [3:0] fl;
    int lat;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.ALU_Sel = '0;

    // Pin the model with hand-computed values.
    chk("model_add_wrap", model(16'hFFFF, 16'h0001, 3'd1), {4'b1010, 16'h0000});
    chk("model_sub_ovf", model(16'h8000, 16'h0001, 3'd2), {4'b0100, 16'h7FFF});
    chk("model_xor", model(16'h0005, 16'h0003, 3'd6), {4'b0000, 16'h0006});

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out", bus.ALU_Out, 16'h0000);
    chk("reset_flags", {bus.flag_c, bus.flag_v, bus.flag_z, bus.flag_n}, 4'b0000);
    chk("reset_handshake", {bus.out_valid, bus.in_ready}, 2'b01);

    run_op(16'hFFFF, 16'h0001, 3'd1, 0, res, fl, lat);
    chk("add_wrap_res", res, 16'h0000);
    chk("add_wrap_flags", fl, 4'b1010);
    chk("add_lat", lat, 0);
    run_op(16'h8000, 16'h0001, 3'd2, 0, res, fl, lat);
    chk("sub_ovf_res", res, 16'h7FFF);
    chk("sub_ovf_flags", fl, 4'b0100);
    run_op(16'h0005, 16'h0003, 3'd6, 4, res, fl, lat);
    chk("xor_stall_res", res, 16'h0006);

    if (MUL_EN) begin
      run_op(16'h0100, 16'h0100, 3'd7, 0, res, fl, lat);
      chk("mul_hi_res", res, 16'h0000);
      chk("mul_hi_flags", fl, 4'b1010);
      chk("mul_lat", lat, W + 1);
      run_op(16'h0007, 16'h0006, 3'd7, 0, res, fl, lat);
      chk("mul_small_res", res, 16'h002A);
      chk("mul_small_flags", fl, 4'b0000);
    end else begin
      run_op(16'h1234, 16'h0002, 3'd7, 0, res, fl, lat);
      chk("mul_off_res", res, 16'h1234);
      chk("mul_off_flags", fl, 4'b0000);
      chk("mul_off_lat", lat, 0);
    end

    // Reset in the middle of an operation (mid-multiply when present).
    bus.in_valid = 1'b1;
    bus.A = 16'h00FF;
    bus.B = 16'h0003;
    bus.ALU_Sel = 3'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_out", bus.ALU_Out, 16'h0000);
    chk("midreset_handshake", {bus.out_valid, bus.in_ready}, 2'b01);
    run_op(16'hABCD, W'($urandom), 3'd3, 0, res, fl, lat);
    chk("clear_res", res, 16'h0000);
    chk("clear_flags", fl, 4'b0010);

    // Random traffic with independent stalls on both sides and rare resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      bus.in_valid = ($urandom % 3) != 0;
      bus.A = rnd_operand();
      bus.B = rnd_operand();
      bus.ALU_Sel = 3'($urandom);
      bus.out_ready = ($urandom % 4) != 0;
      rst = ($urandom % 500) == 0;
    end
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (W + 4) @(negedge clk);
    chk("drain_idle", {bus.out_valid, bus.in_ready}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
